port_ingress: RTL
=================

Name: port_ingress

Overview:
Parametrised successor to the switch input port. Accepts one sop/vld/eop write stream and parses the header word into destination port, priority, length and control-frame flag. Checks the payload length, then buffers words and flags in an internal FIFO. Presents a ready/valid output stream, tagged with parsed fields and a 3-bit batch index, to the switch core. New in this generation: parametrised widths and depth, length checking, overflow and abort handling, and downstream backpressure.

Parameters:
DATA_W, 16, width of wr_data / out_data
PORT_W, 4, dest_port field width (header bits [PORT_W-1:0])
PRIOR_W, 3, priority field width (header bits [PORT_W+PRIOR_W-1:PORT_W])
DEPTH, 32, FIFO entries (power of two, >=4)
AF_TH, 4, almost_full asserted when free entries <= AF_TH

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
wr_sop  in  1  start-of-packet pulse, precedes first wr_vld
wr_eop  in  1  end-of-packet pulse, follows last wr_vld
wr_vld  in  1  wr_data valid
wr_data  in  DATA_W  header word first, then payload
full  out  1  FIFO count >= DEPTH-1
almost_full  out  1  free entries <= AF_TH
out_vld  out  1  output word valid
out_ready  in  1  downstream accept
out_sop  out  1  word is header
out_eop  out  1  word is last of packet
out_err  out  1  packet bad (valid only with out_eop)
out_data  out  DATA_W  word
out_dest_port  out  PORT_W  parsed header field, held for whole packet
out_prior  out  PRIOR_W  parsed header field, held for whole packet
out_is_ctrl  out  1  header length field == 0
out_batch  out  3  payload word index mod 8 (0 on header)
drop_cnt  out  16  saturating count of discarded words

Behaviour:
- Reset (async): FSM=IDLE; FIFO empty; hold register empty; all outputs 0; full=0, almost_full=0 (AF_TH<DEPTH).
- Header fields: length in bytes = hdr[DATA_W-1:PORT_W+PRIOR_W]. Expected payload words = ceil(len*8/DATA_W). len==0 means control frame: header only, zero payload.
- FSM IDLE: wr_sop -> WAIT_HDR. wr_vld in IDLE is discarded and drop_cnt++.
- FSM WAIT_HDR: first wr_vld is the header. Capture it, load the expected count, clear the word counter and sticky err, go to PAYLOAD. wr_eop in WAIT_HDR: nothing pushed, return to IDLE.
- FSM PAYLOAD: each wr_vld increments the word counter. wr_eop compares counter to expected; on mismatch set err. Go to IDLE.
- Hold stage: each accepted word sits in a one-entry hold register. It is pushed when the next wr_vld arrives (eop=0) or at wr_eop (eop=1, err=sticky|mismatch). The header entry carries sop=1. This gives 2-cycle minimum input-to-out_vld latency.
- FIFO entry = {sop,eop,err,data}. Output fields come straight from the FIFO head; out_dest_port/out_prior/out_is_ctrl latch on pop of an sop entry. out_batch counts pops within the packet.
- Handshake: a pop happens when out_vld && out_ready. out_* stay stable while out_vld && !out_ready.
- Push and pop in the same cycle: count unchanged. Push when count==DEPTH: word dropped, drop_cnt++, sticky err set. An already-held word is never lost.
- wr_sop in PAYLOAD (missing eop): push the hold word with eop=1, err=1, then start a new packet in WAIT_HDR.
- wr_sop and wr_eop in the same cycle: eop processed first, then sop.
- Pointers wrap modulo DEPTH. drop_cnt saturates at 16'hFFFF.
- Reset mid-packet: FIFO flushed, partial packet lost, no eop emitted.

Decomposition:
- Package port_pkg: FSM state enum (IDLE, WAIT_HDR, PAYLOAD), fifo entry struct {sop,eop,err,data}, header field offset localparams.
- One sub-module, sync_fifo (DEPTH, entry width), providing count/full/empty. Parser FSM, hold register and output latches live in port_ingress.

Test Plan:
- sop; header 16'h1E92 (dest 2, prior 1, len 61 -> 31 words); 31 payload words; eop -> 32 out words. Header out_sop=1, dest 2, prior 1. Last word out_eop=1, out_err=0. out_batch cycles 1..7,0 over payload.
- Same header, only 9 payload words then eop -> 10 words out, last out_eop=1, out_err=1.
- Control frame header 16'h0045 (len 0, dest 5, prior 4), eop -> single word with out_sop=1, out_eop=1, out_is_ctrl=1, out_err=0.
- out_ready=0, stream 40 words into DEPTH=32 -> almost_full rises at count 28, full at 31; >=8 drops; drop_cnt matches; eop word out_err=1.
- Second sop mid-payload -> first packet ends out_eop=1, out_err=1; second packet intact, out_err=0.
- rst pulse mid-packet -> out_vld=0 and full=0 immediately. Next clean packet passes with out_err=0.

Source files
------------

// File: rtl/port_pkg.sv
// rtl/port_pkg.sv - shared FSM states, FIFO entry flags and header layout for port_ingress
package port_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_HDR = 2'd1,
        PAYLOAD  = 2'd2
    } state_t;

    // A FIFO entry is {entry_flags_t, data}; data width is a parameter of the port.
    typedef struct packed {
        logic sop;
        logic eop;
        logic err;
    } entry_flags_t;

    localparam int FLAG_W       = $bits(entry_flags_t);

    localparam int HDR_DATA_W   = 16;
    localparam int HDR_PORT_W   = 4;
    localparam int HDR_PRIOR_W  = 3;
    localparam int HDR_PORT_LSB = 0;

    function automatic int hdr_prior_lsb(input int port_w);
        return HDR_PORT_LSB + port_w;
    endfunction

    function automatic int hdr_len_lsb(input int port_w, input int prior_w);
        return HDR_PORT_LSB + port_w + prior_w;
    endfunction

    // Payload words needed to carry len_bytes, rounded up to whole words.
    function automatic int payload_words(input int len_bytes, input int data_w);
        return (len_bytes * 8 + data_w - 1) / data_w;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with occupancy count, async active-high reset
module sync_fifo #(
    parameter int DEPTH = 32,
    parameter int WIDTH = 19
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    // DEPTH is a power of two, so the count MSB alone marks full.
    assign full     = count[AW];
    assign empty    = (count == '0);
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/port_ingress.sv
// rtl/port_ingress.sv - switch ingress port: header parse, length check, hold stage, FIFO, ready/valid output
module port_ingress
    import port_pkg::*;
#(
    parameter int DATA_W  = HDR_DATA_W,
    parameter int PORT_W  = HDR_PORT_W,
    parameter int PRIOR_W = HDR_PRIOR_W,
    parameter int DEPTH   = 32,
    parameter int AF_TH   = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wr_sop,
    input  logic               wr_eop,
    input  logic               wr_vld,
    input  logic [DATA_W-1:0]  wr_data,
    output logic               full,
    output logic               almost_full,
    output logic               out_vld,
    input  logic               out_ready,
    output logic               out_sop,
    output logic               out_eop,
    output logic               out_err,
    output logic [DATA_W-1:0]  out_data,
    output logic [PORT_W-1:0]  out_dest_port,
    output logic [PRIOR_W-1:0] out_prior,
    output logic               out_is_ctrl,
    output logic [2:0]         out_batch,
    output logic [15:0]        drop_cnt
);

    localparam int PRIOR_LSB = hdr_prior_lsb(PORT_W);
    localparam int LEN_LSB   = hdr_len_lsb(PORT_W, PRIOR_W);
    localparam int LEN_W     = DATA_W - LEN_LSB;
    localparam int CNT_W     = LEN_W + 3;
    localparam int ENTRY_W   = FLAG_W + DATA_W;
    localparam int AW        = $clog2(DEPTH);

    state_t             state_q, state_d;
    logic               hold_sop_q, hold_sop_d;
    logic [DATA_W-1:0]  hold_data_q, hold_data_d;
    logic [CNT_W-1:0]   word_cnt_q, word_cnt_d;
    logic [CNT_W-1:0]   exp_q, exp_d;
    logic               err_q, err_d;
    logic               drop;
    logic               mismatch;

    logic               push;
    entry_flags_t       push_flags;
    logic [ENTRY_W-1:0] push_entry;
    logic [ENTRY_W-1:0] head;
    entry_flags_t       head_flags;
    logic [DATA_W-1:0]  head_data;
    logic               head_hdr;
    logic [AW:0]        fifo_count;
    logic               fifo_full;
    logic               fifo_empty;
    logic               pop;
    logic               room_mid;
    logic               room_last;

    logic [PORT_W-1:0]  dest_q;
    logic [PRIOR_W-1:0] prior_q;
    logic               ctrl_q;
    logic [2:0]         batch_q;

    assign pop      = !fifo_empty && out_ready;
    assign mismatch = (word_cnt_q != exp_q);

    // The last FIFO slot is reserved for the word that closes a packet, so a
    // mid-packet push stops one entry early and the eop word still gets in.
    assign room_mid  = (int'(fifo_count) < DEPTH - 1) || (pop && !fifo_full);
    assign room_last = !fifo_full || pop;

    assign push_entry = {push_flags, hold_data_q};

    // The hold register is occupied exactly while the FSM is in PAYLOAD.
    always_comb begin
        state_d     = state_q;
        hold_sop_d  = hold_sop_q;
        hold_data_d = hold_data_q;
        word_cnt_d  = word_cnt_q;
        exp_d       = exp_q;
        err_d       = err_q;
        push        = 1'b0;
        push_flags  = '0;
        drop        = 1'b0;

        case (state_q)
            IDLE: begin
                if (wr_vld) begin
                    drop = 1'b1;
                end
                if (wr_sop) begin
                    state_d = WAIT_HDR;
                end
            end

            WAIT_HDR: begin
                if (wr_eop) begin
                    state_d = wr_sop ? WAIT_HDR : IDLE;
                end else if (wr_vld) begin
                    hold_sop_d  = 1'b1;
                    hold_data_d = wr_data;
                    exp_d       = CNT_W'(payload_words(32'(wr_data[DATA_W-1:LEN_LSB]), DATA_W));
                    word_cnt_d  = '0;
                    err_d       = 1'b0;
                    state_d     = PAYLOAD;
                end
            end

            PAYLOAD: begin
                if (wr_eop || wr_sop) begin
                    // A bare sop here means the eop went missing.
                    push_flags.sop = hold_sop_q;
                    push_flags.eop = 1'b1;
                    push_flags.err = err_q | (wr_eop ? mismatch : 1'b1);
                    if (room_last) begin
                        push = 1'b1;
                    end else begin
                        drop = 1'b1;
                    end
                    hold_sop_d = 1'b0;
                    state_d    = wr_sop ? WAIT_HDR : IDLE;
                end else if (wr_vld) begin
                    if (word_cnt_q != '1) begin
                        word_cnt_d = word_cnt_q + CNT_W'(1);
                    end
                    if (room_mid) begin
                        push_flags.sop = hold_sop_q;
                        push           = 1'b1;
                        hold_sop_d     = 1'b0;
                        hold_data_d    = wr_data;
                    end else begin
                        drop  = 1'b1;
                        err_d = 1'b1;
                    end
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            hold_sop_q  <= 1'b0;
            hold_data_q <= '0;
            word_cnt_q  <= '0;
            exp_q       <= '0;
            err_q       <= 1'b0;
            drop_cnt    <= '0;
        end else begin
            state_q     <= state_d;
            hold_sop_q  <= hold_sop_d;
            hold_data_q <= hold_data_d;
            word_cnt_q  <= word_cnt_d;
            exp_q       <= exp_d;
            err_q       <= err_d;
            if (drop && drop_cnt != 16'hFFFF) begin
                drop_cnt <= drop_cnt + 16'd1;
            end
        end
    end

    sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .pop_data  (head),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign head_flags = entry_flags_t'(head[ENTRY_W-1:DATA_W]);
    assign head_data  = head[DATA_W-1:0];
    assign head_hdr   = out_vld && head_flags.sop;

    assign full        = int'(fifo_count) >= DEPTH - 1;
    assign almost_full = int'(fifo_count) >= DEPTH - AF_TH;

    assign out_vld  = !fifo_empty;
    assign out_sop  = out_vld && head_flags.sop;
    assign out_eop  = out_vld && head_flags.eop;
    assign out_err  = out_vld && head_flags.eop && head_flags.err;
    assign out_data = out_vld ? head_data : '0;

    // Header word shows its own fields; payload words show the latched copy.
    assign out_dest_port = head_hdr ? head_data[HDR_PORT_LSB +: PORT_W] : dest_q;
    assign out_prior     = head_hdr ? head_data[PRIOR_LSB +: PRIOR_W] : prior_q;
    assign out_is_ctrl   = head_hdr ? (head_data[DATA_W-1:LEN_LSB] == '0) : ctrl_q;
    assign out_batch     = head_hdr ? 3'd0 : batch_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dest_q  <= '0;
            prior_q <= '0;
            ctrl_q  <= 1'b0;
            batch_q <= 3'd0;
        end else if (pop) begin
            if (head_flags.sop) begin
                dest_q  <= head_data[HDR_PORT_LSB +: PORT_W];
                prior_q <= head_data[PRIOR_LSB +: PRIOR_W];
                ctrl_q  <= (head_data[DATA_W-1:LEN_LSB] == '0);
                batch_q <= 3'd1;
            end else begin
                batch_q <= batch_q + 3'd1;
            end
        end
    end

endmodule
